qspi_psram_master: RTL and testbench
====================================

// Module: qspi_psram_master
// PURPOSE
//   Sequencer for the external QSPI PSRAM. Turns one 32-bit read or write
//   request from the memory-side bus into a complete QSPI transaction:
//   CS#, SCK, and per-lane direction and output data.
//   Sits directly upstream of the four per-lane tri-state IO buffer cells.
//   Drives each cell's dir and out, and samples each cell's in.
// PARAMETERS
//   CLK_DIV      1      SCK half-period in clock cycles (>=1); SCK period = 2*CLK_DIV
//   WAIT_CYCLES  6      dummy SCK cycles between address and read data (>=1)
//   CMD_READ     8'hEB  quad read opcode
//   CMD_WRITE    8'h38  quad write opcode
//   CS_HIGH_MIN  2      minimum clocks cs_n is held high between transactions (>=1)
// PORTS
//   clock       in   1   system clock; single clock domain
//   reset       in   1   synchronous, active-high reset
//   req_valid   in   1   request valid
//   req_ready   out  1   master can accept a request
//   req_we      in   1   1 = write, 0 = read
//   req_addr    in   24  byte address
//   req_wdata   in   32  write data
//   resp_valid  out  1   one-cycle pulse: transaction complete
//   resp_rdata  out  32  read data; valid while resp_valid=1, held until next read completes
//   qspi_cs_n   out  1   chip select, active low
//   qspi_sck    out  1   serial clock, idles low (SPI mode 0)
//   qspi_dir    out  4   per-lane dir to IO buffers (1 = drive)
//   qspi_out    out  4   per-lane output data to IO buffers
//   qspi_in     in   4   per-lane input data from IO buffers
// BEHAVIOUR
//   Reset values
//     req_ready=1, resp_valid=0, resp_rdata=0, cs_n=1, sck=0, dir=0, out=0.
//     FSM in IDLE.
//   Reset mid-transaction: same values on the next clock. The transaction is
//     aborted and produces no resp_valid.
//   Handshake
//     Request accepted on a clock where req_valid & req_ready.
//     req_addr, req_we and req_wdata are captured on that clock.
//     req_ready=1 only in IDLE. It drops the cycle after acceptance.
//     resp_valid is not gated by any ready signal.
//   FSM states: IDLE -> CMD -> ADDR -> (read: WAIT -> DATA | write: DATA) -> GAP -> IDLE
//     CMD   8 SCK cycles, opcode MSB first on lane 0.
//           dir=4'b0001, out[3:1]=0.
//     ADDR  6 SCK cycles, addr[23:20] first, one nibble per cycle.
//           dir=4'b1111.
//     WAIT  WAIT_CYCLES SCK cycles, dir=4'b0000. Entered on reads only.
//     DATA  8 SCK cycles, one nibble each.
//           Write: dir=4'b1111. Read: dir=4'b0000.
//     GAP   cs_n=1, sck=0, dir=0 for CS_HIGH_MIN clocks, then IDLE.
//   SCK timing
//     Each SCK cycle is CLK_DIV clocks low, then CLK_DIV clocks high.
//     out and dir change only on the clock where sck goes 1->0, or at
//     transaction start.
//     qspi_in is sampled on the clock edge that drives sck 0->1, in DATA
//     state only.
//     After the last high phase, sck returns low, and cs_n rises on the
//     same clock that enters GAP.
//   Byte order: little-endian, high nibble first within each byte.
//     Nibble sequence: [7:4],[3:0],[15:12],[11:8],[23:20],[19:16],[31:28],[27:24].
//     Writes shift req_wdata out in this order.
//     Reads assemble resp_rdata in the same order.
//   Latency (CLK_DIV=1, WAIT_CYCLES=6), acceptance on clock T
//     cs_n=0 from T+1.
//     Read: 28 SCK cycles. cs_n=1 and resp_valid=1 at T+57.
//     Write: 22 SCK cycles. cs_n=1 and resp_valid=1 at T+45.
//     req_ready returns to 1 at T+57+CS_HIGH_MIN (read) or T+45+CS_HIGH_MIN (write).
//     General: SCK cycles x 2*CLK_DIV, plus 1.
//   Lane direction switches to input (dir=0) on the falling SCK edge that
//     ends ADDR. The bus is never driven by both ends during WAIT.
//   req_valid held high during a transaction is ignored until IDLE.
// TESTING
//   1. Reset, then read addr=24'h123456; device model returns bytes 11,22,33,44
//      -> opcode EB on lane 0, address nibbles 1..6, 6 dummy cycles,
//      resp_rdata=32'h44332211, resp_valid exactly at T+57.
//   2. Write addr=24'h000010, wdata=32'hDEADBEEF
//      -> opcode 38, lane nibbles E,F,B,E,A,D,D,E, dir=4'hF in ADDR/DATA,
//      resp_valid at T+45, no read sampling.
//   3. Back-to-back: req_valid held high for two reads
//      -> second acceptance only after CS_HIGH_MIN clocks with cs_n=1;
//      exactly two resp_valid pulses.
//   4. CLK_DIV=3 read
//      -> SCK high and low phases of 3 clocks each; resp_valid at T+1+28*6.
//   5. Assert reset during DATA of a read
//      -> next clock: cs_n=1, sck=0, dir=0, req_ready=1; no resp_valid.
//      A following read completes correctly.
//   6. Check dir never =1 on any lane during WAIT or read DATA,
//      and sck stays 0 whenever cs_n=1, throughout all scenarios.

Source files
------------

// File: rtl/qspi_psram_master.sv
// qspi_psram_master
//   Sequencer for an external quad-SPI PSRAM. Converts one 32-bit read or
//   write request into a full QSPI transaction (opcode, 24-bit address,
//   optional dummy cycles, 8 data nibbles) and drives the four per-lane
//   tri-state IO buffer cells (dir/out) while sampling their inputs.
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   req_valid/req_ready     request handshake; req_we selects write
//   req_addr, req_wdata     byte address and write data, captured on accept
//   resp_valid, resp_rdata  one-cycle completion pulse; read data (held)
//   qspi_cs_n, qspi_sck     chip select (active low), serial clock (mode 0)
//   qspi_dir, qspi_out      per-lane drive enable and output data
//   qspi_in                 per-lane input data
module qspi_psram_master #(
  parameter int unsigned CLK_DIV     = 1,
  parameter int unsigned WAIT_CYCLES = 6,
  parameter logic [7:0]  CMD_READ    = 8'hEB,
  parameter logic [7:0]  CMD_WRITE   = 8'h38,
  parameter int unsigned CS_HIGH_MIN = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        qspi_cs_n,
  output logic        qspi_sck,
  output logic [3:0]  qspi_dir,
  output logic [3:0]  qspi_out,
  input  logic [3:0]  qspi_in
);

  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WAIT, S_DATA, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] div_q, div_d, cnt_q, cnt_d;
  logic          sck_q, sck_d, cs_n_q, cs_n_d, we_q, we_d;
  logic          resp_valid_q, resp_valid_d;
  logic [3:0]    dir_q, dir_d, out_q, out_d;
  logic [6:0]    cmd_q, cmd_d;
  logic [23:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d, rdata_q, rdata_d;
  logic [7:0]    opcode;
  logic          phase_end, last_cyc;

  // Data nibbles travel MSB-first through data_q; a byte swap maps the
  // little-endian, high-nibble-first wire order onto that layout.
  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      cnt_q        <= '0;
      sck_q        <= 1'b0;
      cs_n_q       <= 1'b1;
      we_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      dir_q        <= '0;
      out_q        <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      sck_q        <= sck_d;
      cs_n_q       <= cs_n_d;
      we_q         <= we_d;
      resp_valid_q <= resp_valid_d;
      dir_q        <= dir_d;
      out_q        <= out_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    sck_d        = sck_q;
    cs_n_d       = cs_n_q;
    we_d         = we_q;
    resp_valid_d = 1'b0;
    dir_d        = dir_q;
    out_d        = out_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    data_d       = data_q;
    rdata_d      = rdata_q;
    opcode       = req_we ? CMD_WRITE : CMD_READ;
    phase_end    = (div_q == CW'(CLK_DIV - 1));
    case (state_q)
      S_CMD:   last_cyc = (cnt_q == CW'(7));
      S_ADDR:  last_cyc = (cnt_q == CW'(5));
      S_WAIT:  last_cyc = (cnt_q == CW'(WAIT_CYCLES - 1));
      S_DATA:  last_cyc = (cnt_q == CW'(7));
      default: last_cyc = 1'b0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_CMD;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          div_d   = '0;
          cnt_d   = '0;
          we_d    = req_we;
          dir_d   = 4'b0001;
          out_d   = {3'b000, opcode[7]};
          cmd_d   = opcode[6:0];
          addr_d  = req_addr;
          data_d  = bswap(req_wdata);
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(CS_HIGH_MIN - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (!phase_end) begin
          div_d = div_q + CW'(1);
        end else begin
          div_d = '0;
          if (!sck_q) begin
            // Rising SCK: the only point where read data is captured.
            sck_d = 1'b1;
            if (state_q == S_DATA && !we_q) data_d = {data_q[27:0], qspi_in};
          end else begin
            // Falling SCK: end of one SCK cycle, present the next nibble.
            sck_d = 1'b0;
            if (!last_cyc) begin
              cnt_d = cnt_q + CW'(1);
              case (state_q)
                S_CMD: begin
                  out_d = {3'b000, cmd_q[6]};
                  cmd_d = {cmd_q[5:0], 1'b0};
                end
                S_ADDR: begin
                  out_d  = addr_q[19:16];
                  addr_d = {addr_q[19:0], 4'h0};
                end
                S_DATA: begin
                  if (we_q) begin
                    out_d  = data_q[27:24];
                    data_d = {data_q[27:0], 4'h0};
                  end
                end
                default: ;
              endcase
            end else begin
              cnt_d = '0;
              case (state_q)
                S_CMD: begin
                  state_d = S_ADDR;
                  dir_d   = 4'hF;
                  out_d   = addr_q[23:20];
                end
                S_ADDR: begin
                  if (we_q) begin
                    state_d = S_DATA;
                    dir_d   = 4'hF;
                    out_d   = data_q[31:28];
                  end else begin
                    state_d = S_WAIT;
                    dir_d   = '0;
                    out_d   = '0;
                  end
                end
                S_WAIT: state_d = S_DATA;
                default: begin
                  state_d      = S_GAP;
                  cs_n_d       = 1'b1;
                  dir_d        = '0;
                  out_d        = '0;
                  resp_valid_d = 1'b1;
                  if (!we_q) rdata_d = bswap(data_q);
                end
              endcase
            end
          end
        end
      end
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign qspi_cs_n  = cs_n_q;
  assign qspi_sck   = sck_q;
  assign qspi_dir   = dir_q;
  assign qspi_out   = out_q;

endmodule

// File: tb/tb_qspi_psram_master.sv
// tb_qspi_psram_master
//   Self-checking bench for qspi_psram_master. Two instances share the clock:
//   dut0 with CLK_DIV=1 and dut3 with CLK_DIV=3. A PSRAM model per instance
//   watches CS#/SCK, records each SCK cycle's lane direction and data, and
//   returns read bytes on the falling edges preceding data cycles.
module tb_qspi_psram_master;
  localparam int unsigned WAITC  = 6;
  localparam int unsigned GAPMIN = 2;
  localparam logic [7:0]  OP_RD  = 8'hEB;
  localparam logic [7:0]  OP_WR  = 8'h38;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        req_valid [2], req_ready [2], req_we [2], resp_valid [2];
  logic        cs_n [2], sck [2];
  logic [23:0] req_addr [2];
  logic [31:0] req_wdata [2], resp_rdata [2];
  logic [3:0]  dir [2], qout [2], qin [2];

  qspi_psram_master #(.CLK_DIV(1), .WAIT_CYCLES(WAITC), .CMD_READ(OP_RD),
                      .CMD_WRITE(OP_WR), .CS_HIGH_MIN(GAPMIN)) dut0 (
    .clock(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .qspi_cs_n(cs_n[0]),
    .qspi_sck(sck[0]), .qspi_dir(dir[0]), .qspi_out(qout[0]), .qspi_in(qin[0]));

  qspi_psram_master #(.CLK_DIV(3), .WAIT_CYCLES(WAITC), .CMD_READ(OP_RD),
                      .CMD_WRITE(OP_WR), .CS_HIGH_MIN(GAPMIN)) dut3 (
    .clock(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .qspi_cs_n(cs_n[1]),
    .qspi_sck(sck[1]), .qspi_dir(dir[1]), .qspi_out(qout[1]), .qspi_in(qin[1]));

  int          checks = 0, errors = 0;
  int          div_of [2];
  int          rises [2], run [2], viol [2], vbase [2], capn [2], resp_cnt [2], cs_high [2];
  logic        prev_sck [2], prev_cs [2];
  logic [7:0]  cap [2][32];
  logic        mon_en = 1'b0;
  logic        mon_we [2];
  logic [31:0] dev_word [2];
  logic [31:0] exp_rdata [2];

  // Nibble k of a 32-bit word on the wire: byte k/2, high nibble first.
  function automatic logic [3:0] wire_nib(input logic [31:0] w, input int k);
    logic [7:0] b;
    b = w[8*(k/2) +: 8];
    return (k % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // PSRAM model and bus-protocol watcher, sampled 1 time unit after each edge.
  initial begin
    for (int i = 0; i < 2; i++) begin
      rises[i] = 0; run[i] = 0; viol[i] = 0; capn[i] = 0; resp_cnt[i] = 0;
      cs_high[i] = 100; prev_sck[i] = 1'b0; prev_cs[i] = 1'b1; qin[i] = 4'h0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        for (int i = 0; i < 2; i++) begin
          int k, idx;
          if (resp_valid[i]) resp_cnt[i]++;
          if (cs_n[i] === 1'b1 && sck[i] !== 1'b0) viol[i]++;
          if (cs_n[i] === 1'b1) begin
            if (!prev_cs[i] && !rst[i] && run[i] != div_of[i]) viol[i]++;
            cs_high[i] = prev_cs[i] ? cs_high[i] + 1 : 1;
            rises[i] = 0;
            qin[i] = 4'($urandom);
          end else begin
            if (prev_cs[i]) begin
              if (cs_high[i] < int'(GAPMIN)) viol[i]++;
              if (sck[i] !== 1'b0) viol[i]++;
              run[i] = 1; capn[i] = 0; rises[i] = 0;
            end else if (sck[i] != prev_sck[i]) begin
              if (run[i] != div_of[i]) viol[i]++;
              run[i] = 1;
              if (sck[i]) begin
                rises[i]++;
                if (capn[i] < 32) begin
                  cap[i][capn[i]] = {dir[i], qout[i]};
                  capn[i]++;
                end
              end else begin
                k = rises[i] - (14 + int'(WAITC));
                if (!mon_we[i] && k >= 0 && k < 8) qin[i] = wire_nib(dev_word[i], k);
                else qin[i] = 4'($urandom);
              end
            end else begin
              run[i]++;
            end
            idx = sck[i] ? rises[i] - 1 : rises[i];
            if (!mon_we[i] && idx >= 14 && dir[i] !== 4'h0) viol[i]++;
          end
          prev_cs[i]  = cs_n[i];
          prev_sck[i] = sck[i];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic txn(input int i, input bit we, input logic [23:0] a,
                     input logic [31:0] wd, input logic [31:0] dw, input bit hold);
    int ncyc, edges, n, bad, badk;
    logic [7:0] op, e, m;
    op    = we ? OP_WR : OP_RD;
    ncyc  = we ? 22 : 14 + int'(WAITC) + 8;
    edges = ncyc * 2 * div_of[i];
    dev_word[i] = dw;
    mon_we[i]   = we;
    req_we[i] = we; req_addr[i] = a; req_wdata[i] = wd; req_valid[i] = 1'b1;
    n = 0;
    while (!req_ready[i] && n < 400) begin tick(); n++; end
    chk($sformatf("ready_before_accept[%0d]", i), req_ready[i], 1);
    tick();
    if (!hold) req_valid[i] = 1'b0;
    chk($sformatf("cs_low_after_accept[%0d]", i), cs_n[i], 0);
    chk($sformatf("ready_drop[%0d]", i), req_ready[i], 0);
    n = 0;
    while (!resp_valid[i] && n < edges + 100) begin tick(); n++; end
    chk($sformatf("resp_latency[%0d]", i), 64'(n), 64'(edges));
    chk($sformatf("cs_high_at_resp[%0d]", i), cs_n[i], 1);
    if (!we) exp_rdata[i] = dw;
    chk($sformatf("rdata[%0d]", i), resp_rdata[i], exp_rdata[i]);
    bad = 0; badk = -1;
    for (int k = 0; k < ncyc; k++) begin
      m = 8'hFF;
      if (k < 8)        e = {4'b0001, 3'b000, op[7-k]};
      else if (k < 14)  e = {4'hF, a[23-4*(k-8) -: 4]};
      else if (!we) begin e = 8'h00; m = 8'hF0; end
      else              e = {4'hF, wire_nib(wd, k - 14)};
      if (((cap[i][k] ^ e) & m) != 8'h00) begin
        bad++;
        if (badk < 0) badk = k;
      end
    end
    chk($sformatf("sck_cycles[%0d]", i), 64'(capn[i]), 64'(ncyc));
    chk($sformatf("lane_seq_first_bad_cycle[%0d]", i), 64'(badk), 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk($sformatf("resp_one_cycle[%0d]", i), resp_valid[i], 0);
    n = 1;
    while (!req_ready[i] && n < 50) begin tick(); n++; end
    chk($sformatf("gap_len[%0d]", i), 64'(n), 64'(GAPMIN));
    chk($sformatf("rdata_held[%0d]", i), resp_rdata[i], exp_rdata[i]);
    chk($sformatf("protocol_violations[%0d]", i), 64'(viol[i] - vbase[i]), 0);
    vbase[i] = viol[i];
  endtask

  initial begin
    int rc;
    div_of[0] = 1; div_of[1] = 3;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; mon_we[i] = 1'b0; dev_word[i] = '0; exp_rdata[i] = '0;
      vbase[i] = 0;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready[%0d]", i), req_ready[i], 1);
      chk($sformatf("rst_resp_valid[%0d]", i), resp_valid[i], 0);
      chk($sformatf("rst_rdata[%0d]", i), resp_rdata[i], 0);
      chk($sformatf("rst_pins[%0d]", i), {cs_n[i], sck[i], dir[i], qout[i]}, 10'b1_0_0000_0000);
      rst[i] = 1'b0;
    end
    mon_en = 1'b1;
    tick();

    // Directed read and write on the CLK_DIV=1 instance.
    txn(0, 1'b0, 24'h123456, 32'h0, 32'h44332211, 1'b0);
    txn(0, 1'b1, 24'h000010, 32'hDEADBEEF, 32'h0, 1'b0);

    // Back-to-back reads with req_valid held high.
    rc = resp_cnt[0];
    txn(0, 1'b0, 24'hA5A5A5, 32'h0, 32'h89ABCDEF, 1'b1);
    txn(0, 1'b0, 24'h5A5A5A, 32'h0, 32'h01234567, 1'b0);
    repeat (10) tick();
    chk("b2b_resp_pulses", 64'(resp_cnt[0] - rc), 2);

    // CLK_DIV=3 read.
    txn(1, 1'b0, 24'hABCDEF, 32'h0, 32'hCAFEF00D, 1'b0);

    // Reset during read DATA, then a clean read.
    req_we[0] = 1'b0; req_addr[0] = 24'h0F0F0F; dev_word[0] = 32'h11111111;
    mon_we[0] = 1'b0; req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    repeat (44) tick();
    chk("abort_in_progress_cs", cs_n[0], 0);
    rst[0] = 1'b1;
    rc = resp_cnt[0];
    tick();
    rst[0] = 1'b0;
    exp_rdata[0] = '0;
    chk("abort_pins", {cs_n[0], sck[0], dir[0]}, 6'b1_0_0000);
    chk("abort_ready", req_ready[0], 1);
    chk("abort_resp_valid", resp_valid[0], 0);
    repeat (80) tick();
    chk("abort_no_resp", 64'(resp_cnt[0] - rc), 0);
    vbase[0] = viol[0];
    txn(0, 1'b0, 24'h345678, 32'h0, 32'h76543210, 1'b0);

    // Randomized mix on both instances.
    for (int r = 0; r < 8; r++) begin
      txn(r % 2, 1'($urandom), 24'($urandom), $urandom, $urandom, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
